mem_sram_agent: RTL and testbench
=================================

// Module: mem_sram_agent
// PURPOSE
//  MEM-stage data-memory agent; the consumer end of the EX/MEM load/store fields (aluop, mem_addr, reg2).
//  Decodes the load/store op and drives the data SRAM port (en, byte-wen, word address, lane-replicated wdata).
//  Waits out the SRAM read latency, holding the pipeline via stallreq to ctrl.
//  Returns the lane-extracted, sign/zero-extended load result to MEM for the MEM/WB write.
// PARAMETERS
//  RD_LATENCY   1   cycles from data_sram_en (read) to data_sram_rdata valid; legal range 1..7
// PORTS
//  clk             in   1   clock
//  rst             in   1   reset, synchronous, active-high
//  req_valid       in   1   MEM stage holds a valid instruction
//  mem_aluop       in   8   op subtype (AluOpBus)
//  mem_addr        in   32  effective byte address
//  mem_reg2        in   32  store source data
//  flush           in   1   exception flush; aborts any access in progress
//  data_sram_en    out  1   SRAM access enable
//  data_sram_wen   out  4   byte write enables; 0 = read
//  data_sram_addr  out  32  {mem_addr[31:2],2'b00}
//  data_sram_wdata out  32  lane-replicated store data
//  data_sram_rdata in   32  read data, valid RD_LATENCY cycles after the read issue cycle
//  load_data       out  32  extended load result
//  load_valid      out  1   load_data valid this cycle
//  stallreq        out  1   stall request to ctrl
//  exc_adel        out  1   load address error (MEM_ALIGN_CHECK_EN only)
//  exc_ades        out  1   store address error (MEM_ALIGN_CHECK_EN only)
// BEHAVIOUR
//  - Ops: LB 8'hE0, LBU 8'hE4, LH 8'hE1, LHU 8'hE5, LW 8'hE3, SB 8'hE8, SH 8'hE9, SW 8'hEB; all others = no access.
//  - Reset: every output 0, FSM IDLE, wait counter 0. Reset mid-access drops it; no late load_valid.
//  - FSM IDLE/WAIT/DONE. SRAM outputs are combinational from the inputs in IDLE only, and 0 in WAIT/DONE.
//  - Store in IDLE: en=1 for 1 cycle, no stall, remain IDLE.
//    wen: SB 4'b0001<<addr[1:0]; SH addr[1]?4'b1100:4'b0011; SW 4'b1111.
//    wdata: SB {4{reg2[7:0]}}, SH {2{reg2[15:0]}}, SW reg2.
//  - Load in IDLE: en=1, wen=0, stallreq=1. Latch addr[1:0] and op; counter=1; go to WAIT.
//  - WAIT: stallreq=1; counter increments. When counter==RD_LATENCY: capture rdata, extract, go to DONE.
//  - Extraction: byte = rdata[8*a+:8]; half = rdata[16*a[1]+:16]. LB/LH sign-extend, LBU/LHU zero-extend.
//  - DONE: load_valid=1, load_data held, stallreq=0. The pipeline advances at the end of this cycle.
//    The held request is NOT reissued. Next state IDLE.
//  - load_data holds its last value until the next capture; load_valid is a 1-cycle pulse.
//  - flush in WAIT or DONE: go to IDLE next cycle, stallreq=0, load_valid=0.
//    flush in IDLE masks en (no access issued).
//  - flush takes priority over a simultaneous capture.
//  - req_valid=0 or non-memory op in IDLE: all SRAM outputs 0, stallreq 0.
// CONFIGURATION
//  - MEM_ALIGN_CHECK_EN defined:
//    LH/LHU with addr[0]=1, or LW with addr[1:0]!=0 -> exc_adel=1 (combinational, IDLE); no SRAM access, no stall.
//    SH/SW under the same rule -> exc_ades=1; no SRAM access.
//  - MEM_ALIGN_CHECK_EN undefined:
//    No check. SH/LH ignore addr[0]; SW/LW ignore addr[1:0]. exc_adel/exc_ades tied 0.
// STRUCTURE
//  - defines.v (shared): the EXE_*_OP codes above, ZeroWord, Stop/NoStop, state encodings MSA_IDLE/MSA_WAIT/MSA_DONE.
//  - One sub-module: mem_load_extract (combinational: rdata, addr[1:0], op -> load_data).
//    It is reused by the WB forwarding path.
//  - FSM, latency counter and SRAM drive logic live in the top module.
// TESTING
//  - SW addr 0x1000, reg2 0xDEADBEEF -> en=1, wen=4'hF, addr 0x1000, wdata 0xDEADBEEF; stallreq 0.
//  - SB addr 0x1003, reg2 0x000000A5 -> wen=4'b1000, wdata 0xA5A5A5A5.
//  - LB addr 0x2001, rdata 0x1234_80FF, RD_LATENCY=1 -> stallreq for 2 cycles; DONE: load_valid=1, load_data 0xFFFFFF80.
//    Repeat with LBU -> 0x00000080.
//  - LH addr 0x2002, RD_LATENCY=3, rdata 0x8001_0000 -> stallreq high 4 cycles; load_data 0xFFFF8001.
//    Exactly one en pulse issued.
//  - LW issued, flush asserted in WAIT -> IDLE next cycle; load_valid never asserted; no further en.
//  - MEM_ALIGN_CHECK_EN: LW addr 0x3002 -> exc_adel=1, en=0, stallreq=0.
//    Without the macro: en=1, addr 0x3000.

Source files
------------

// File: rtl/mem_sram_agent_pkg.sv
// rtl/mem_sram_agent_pkg.sv - load/store op codes, FSM states and lane helpers for mem_sram_agent
package mem_sram_agent_pkg;

  localparam logic [7:0] EXE_LB_OP  = 8'hE0;
  localparam logic [7:0] EXE_LBU_OP = 8'hE4;
  localparam logic [7:0] EXE_LH_OP  = 8'hE1;
  localparam logic [7:0] EXE_LHU_OP = 8'hE5;
  localparam logic [7:0] EXE_LW_OP  = 8'hE3;
  localparam logic [7:0] EXE_SB_OP  = 8'hE8;
  localparam logic [7:0] EXE_SH_OP  = 8'hE9;
  localparam logic [7:0] EXE_SW_OP  = 8'hEB;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;
  localparam logic        Stop     = 1'b1;
  localparam logic        NoStop   = 1'b0;

  typedef enum logic [1:0] {
    MSA_IDLE = 2'd0,
    MSA_WAIT = 2'd1,
    MSA_DONE = 2'd2
  } msa_state_e;

  function automatic logic is_load_op(input logic [7:0] op);
    return (op == EXE_LB_OP) || (op == EXE_LBU_OP) || (op == EXE_LH_OP) ||
           (op == EXE_LHU_OP) || (op == EXE_LW_OP);
  endfunction

  function automatic logic is_store_op(input logic [7:0] op);
    return (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
  endfunction

  // Halfword ops need addr[0]==0, word ops need addr[1:0]==0.
  function automatic logic misaligned(input logic [7:0] op, input logic [1:0] a);
    case (op)
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: return a[0];
      EXE_LW_OP, EXE_SW_OP:             return a != 2'b00;
      default:                          return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] store_wen(input logic [7:0] op, input logic [1:0] a);
    case (op)
      EXE_SB_OP: return 4'b0001 << a;
      EXE_SH_OP: return a[1] ? 4'b1100 : 4'b0011;
      EXE_SW_OP: return 4'b1111;
      default:   return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] store_wdata(input logic [7:0] op, input logic [31:0] d);
    case (op)
      EXE_SB_OP: return {4{d[7:0]}};
      EXE_SH_OP: return {2{d[15:0]}};
      default:   return d;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_extract.sv
// rtl/mem_load_extract.sv - lane select and sign/zero extension of SRAM read data (shared with WB forwarding)
module mem_load_extract
  import mem_sram_agent_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_addr_lo,
  input  logic [7:0]  i_aluop,
  output logic [31:0] o_load_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
  assign w_half = i_rdata[{i_addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    o_load_data = i_rdata;
    case (i_aluop)
      EXE_LB_OP:  o_load_data = {{24{w_byte[7]}}, w_byte};
      EXE_LBU_OP: o_load_data = {24'h000000, w_byte};
      EXE_LH_OP:  o_load_data = {{16{w_half[15]}}, w_half};
      EXE_LHU_OP: o_load_data = {16'h0000, w_half};
      default:    o_load_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/mem_sram_agent.sv
// rtl/mem_sram_agent.sv - MEM-stage data SRAM agent; MEM_ALIGN_CHECK_EN enables address-error detection
module mem_sram_agent
  import mem_sram_agent_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic [7:0]  mem_aluop,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_reg2,
  input  logic        flush,
  output logic        data_sram_en,
  output logic [3:0]  data_sram_wen,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  input  logic [31:0] data_sram_rdata,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        stallreq,
  output logic        exc_adel,
  output logic        exc_ades
);

  localparam logic [2:0] LAT = 3'(RD_LATENCY);

  msa_state_e  r_state;
  logic [2:0]  r_cnt;
  logic [1:0]  r_addr_lo;
  logic [7:0]  r_op;
  logic [31:0] r_load_data;

  logic        w_idle;
  logic        w_is_load;
  logic        w_is_store;
  logic        w_misalign;
  logic        w_go;
  logic        w_ld_issue;
  logic        w_st_issue;
  logic [31:0] w_ext;

  assign w_idle     = (r_state == MSA_IDLE) && !rst;
  assign w_is_load  = is_load_op(mem_aluop);
  assign w_is_store = is_store_op(mem_aluop);

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misalign = misaligned(mem_aluop, mem_addr[1:0]);
  assign exc_adel   = w_idle && req_valid && w_is_load && w_misalign;
  assign exc_ades   = w_idle && req_valid && w_is_store && w_misalign;
`else
  assign w_misalign = 1'b0;
  assign exc_adel   = 1'b0;
  assign exc_ades   = 1'b0;
`endif

  assign w_go       = w_idle && req_valid && !flush && !w_misalign;
  assign w_ld_issue = w_go && w_is_load;
  assign w_st_issue = w_go && w_is_store;

  // SRAM port is only driven from IDLE; WAIT/DONE keep it quiet so nothing is reissued.
  assign data_sram_en    = w_ld_issue || w_st_issue;
  assign data_sram_wen   = w_st_issue ? store_wen(mem_aluop, mem_addr[1:0]) : 4'b0000;
  assign data_sram_addr  = data_sram_en ? {mem_addr[31:2], 2'b00} : ZeroWord;
  assign data_sram_wdata = w_st_issue ? store_wdata(mem_aluop, mem_reg2) : ZeroWord;

  assign stallreq   = (w_ld_issue || (r_state == MSA_WAIT && !flush && !rst)) ? Stop : NoStop;
  assign load_valid = (r_state == MSA_DONE) && !flush && !rst;
  assign load_data  = r_load_data;

  mem_load_extract u_extract (
    .i_rdata    (data_sram_rdata),
    .i_addr_lo  (r_addr_lo),
    .i_aluop    (r_op),
    .o_load_data(w_ext)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= MSA_IDLE;
      r_cnt       <= 3'd0;
      r_addr_lo   <= 2'b00;
      r_op        <= 8'h00;
      r_load_data <= ZeroWord;
    end else begin
      case (r_state)
        MSA_IDLE: begin
          if (w_ld_issue) begin
            r_addr_lo <= mem_addr[1:0];
            r_op      <= mem_aluop;
            r_cnt     <= 3'd1;
            r_state   <= MSA_WAIT;
          end
        end
        MSA_WAIT: begin
          if (flush) begin
            r_cnt   <= 3'd0;
            r_state <= MSA_IDLE;
          end else if (r_cnt == LAT) begin
            r_load_data <= w_ext;
            r_cnt       <= 3'd0;
            r_state     <= MSA_DONE;
          end else begin
            r_cnt <= r_cnt + 3'd1;
          end
        end
        MSA_DONE: r_state <= MSA_IDLE;
        default:  r_state <= MSA_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_sram_agent.sv
// tb/tb_mem_sram_agent.sv - self-checking bench: two agents (latency 1 and 3) against a byte-level memory model
module tb_mem_sram_agent;

  localparam int LAT0 = 1;
  localparam int LAT1 = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid [2];
  logic [7:0]  aluop     [2];
  logic [31:0] maddr     [2];
  logic [31:0] reg2      [2];
  logic        flush     [2];
  logic        en        [2];
  logic [3:0]  wen       [2];
  logic [31:0] saddr     [2];
  logic [31:0] wdata     [2];
  logic [31:0] rdata     [2];
  logic [31:0] ld        [2];
  logic        lv        [2];
  logic        stall     [2];
  logic        adel      [2];
  logic        ades      [2];

  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  mem_sram_agent #(.RD_LATENCY(LAT0)) u_dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .mem_aluop(aluop[0]), .mem_addr(maddr[0]),
    .mem_reg2(reg2[0]), .flush(flush[0]), .data_sram_en(en[0]), .data_sram_wen(wen[0]),
    .data_sram_addr(saddr[0]), .data_sram_wdata(wdata[0]), .data_sram_rdata(rdata[0]),
    .load_data(ld[0]), .load_valid(lv[0]), .stallreq(stall[0]), .exc_adel(adel[0]), .exc_ades(ades[0])
  );

  mem_sram_agent #(.RD_LATENCY(LAT1)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .mem_aluop(aluop[1]), .mem_addr(maddr[1]),
    .mem_reg2(reg2[1]), .flush(flush[1]), .data_sram_en(en[1]), .data_sram_wen(wen[1]),
    .data_sram_addr(saddr[1]), .data_sram_wdata(wdata[1]), .data_sram_rdata(rdata[1]),
    .load_data(ld[1]), .load_valid(lv[1]), .stallreq(stall[1]), .exc_adel(adel[1]), .exc_ades(ades[1])
  );

  // SRAM model per agent: word store keyed by {agent, byte address}; read data appears exactly
  // RD_LATENCY cycles after the issue cycle, random junk in every other cycle.
  logic [31:0] smem [bit [32:0]];
  logic [31:0] pipe [2][8];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic [31:0] v;
      logic [31:0] w;
      bit [32:0]   key;
      v   = $urandom;
      key = {k[0], saddr[k][31:2], 2'b00};
      if (en[k] && wen[k] == 4'h0) begin
        v = smem.exists(key) ? smem[key] : 32'h0;
      end else if (en[k]) begin
        w = smem.exists(key) ? smem[key] : 32'h0;
        for (int b = 0; b < 4; b++)
          if (wen[k][b]) w[8*b +: 8] = wdata[k][8*b +: 8];
        smem[key] = w;
      end
      for (int i = 7; i > 0; i--) pipe[k][i] <= pipe[k][i-1];
      pipe[k][0] <= v;
    end
  end

  always_comb begin
    rdata[0] = pipe[0][LAT0-1];
    rdata[1] = pipe[1][LAT1-1];
  end

  // Reference: flat little-endian byte memory per agent.
  logic [7:0] refb [bit [32:0]];

  function automatic int lat_of(input int k);
    return (k == 0) ? LAT0 : LAT1;
  endfunction

  function automatic logic [7:0] rb(input int k, input logic [31:0] a);
    bit [32:0] key;
    key = {k[0], a};
    return refb.exists(key) ? refb[key] : 8'h00;
  endfunction

  function automatic logic is_ld(input logic [7:0] op);
    return op == 8'hE0 || op == 8'hE4 || op == 8'hE1 || op == 8'hE5 || op == 8'hE3;
  endfunction

  function automatic logic is_st(input logic [7:0] op);
    return op == 8'hE8 || op == 8'hE9 || op == 8'hEB;
  endfunction

  function automatic logic [31:0] ref_load(input int k, input logic [7:0] op, input logic [31:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] w;
    logic [31:0] hb;
    logic [31:0] wb;
    hb = a & ~32'd1;
    wb = a & ~32'd3;
    b  = rb(k, a);
    h  = {rb(k, hb + 1), rb(k, hb)};
    w  = {rb(k, wb + 3), rb(k, wb + 2), rb(k, wb + 1), rb(k, wb)};
    case (op)
      8'hE0:   return 32'($signed(b));
      8'hE4:   return 32'(b);
      8'hE1:   return 32'($signed(h));
      8'hE5:   return 32'(h);
      default: return w;
    endcase
  endfunction

  task automatic ref_store(input int k, input logic [7:0] op, input logic [31:0] a, input logic [31:0] d);
    int n;
    logic [31:0] base;
    n    = (op == 8'hE8) ? 1 : (op == 8'hE9) ? 2 : 4;
    base = a & ~(32'(n) - 1);
    for (int i = 0; i < n; i++) refb[{k[0], base + 32'(i)}] = d[8*i +: 8];
  endtask

  task automatic preload(input int k, input logic [31:0] a, input logic [31:0] w);
    smem[{k[0], a[31:2], 2'b00}] = w;
    for (int i = 0; i < 4; i++) refb[{k[0], a[31:2], 2'b00} + 33'(i)] = w[8*i +: 8];
  endtask

  task automatic idle_inputs();
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = 1'b0; aluop[k] = 8'h00; maddr[k] = 32'h0; reg2[k] = 32'h0; flush[k] = 1'b0;
    end
  endtask

  // One MEM-stage instruction: hold the request until stallreq drops, recording what the port did.
  task automatic do_access(input int k, input logic v, input logic [7:0] op, input logic [31:0] a,
                           input logic [31:0] d, output int n_stall, output int n_en, output int n_lv,
                           output logic [3:0] wen_o, output logic [31:0] addr_o, output logic [31:0] wdata_o,
                           output logic [31:0] ld_o, output logic [1:0] exc_o);
    @(posedge clk); #1;
    req_valid[k] = v; aluop[k] = op; maddr[k] = a; reg2[k] = d; flush[k] = 1'b0;
    n_stall = 0; n_en = 0; n_lv = 0; wen_o = 0; addr_o = 0; wdata_o = 0; ld_o = 0;
    exc_o = 2'b00;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (c == 0) exc_o = {adel[k], ades[k]};
      if (en[k]) begin
        n_en++;
        if (n_en == 1) begin wen_o = wen[k]; addr_o = saddr[k]; wdata_o = wdata[k]; end
      end
      if (lv[k]) begin n_lv++; ld_o = ld[k]; end
      if (!stall[k]) break;
      n_stall++;
      @(posedge clk); #1;
    end
  endtask

  int          s_stall, s_en, s_lv;
  logic [3:0]  s_wen;
  logic [31:0] s_addr, s_wdata, s_ld;
  logic [1:0]  s_exc;

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    req_valid[0] = 1'b1; aluop[0] = 8'hE3; maddr[0] = 32'h2000;
    req_valid[1] = 1'b1; aluop[1] = 8'hEB; maddr[1] = 32'h2000; reg2[1] = 32'hFFFF_FFFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if ({en[k], wen[k], saddr[k], wdata[k], ld[k], lv[k], stall[k], adel[k], ades[k]} !== '0)
        $display("FAIL reset_outputs[%0d]: got en=%b wen=%h addr=%h wdata=%h ld=%h lv=%b stall=%b, want all 0",
                 k, en[k], wen[k], saddr[k], wdata[k], ld[k], lv[k], stall[k]);
      else n_pass++;
    end
    @(posedge clk); #1;
    rst = 1'b0;
    idle_inputs();
  endtask

  task automatic test_store();
    do_access(0, 1'b1, 8'hEB, 32'h1000, 32'hDEADBEEF, s_stall, s_en, s_lv, s_wen, s_addr, s_wdata, s_ld, s_exc);
    ref_store(0, 8'hEB, 32'h1000, 32'hDEADBEEF);
    n_checks++;
    if ({s_en, s_stall, s_wen, s_addr, s_wdata} !== {32'd1, 32'd0, 4'hF, 32'h1000, 32'hDEADBEEF})
      $display("FAIL sw_port: got en=%0d stall=%0d wen=%h addr=%h wdata=%h, want 1 0 f 00001000 deadbeef",
               s_en, s_stall, s_wen, s_addr, s_wdata);
    else n_pass++;
    do_access(0, 1'b1, 8'hE8, 32'h1003, 32'h000000A5, s_stall, s_en, s_lv, s_wen, s_addr, s_wdata, s_ld, s_exc);
    ref_store(0, 8'hE8, 32'h1003, 32'h000000A5);
    n_checks++;
    if ({s_en, s_stall, s_wen, s_addr, s_wdata} !== {32'd1, 32'd0, 4'b1000, 32'h1000, 32'hA5A5A5A5})
      $display("FAIL sb_port: got en=%0d stall=%0d wen=%b addr=%h wdata=%h, want 1 0 1000 00001000 a5a5a5a5",
               s_en, s_stall, s_wen, s_addr, s_wdata);
    else n_pass++;
    do_access(0, 1'b1, 8'hE3, 32'h1000, 32'h0, s_stall, s_en, s_lv, s_wen, s_addr, s_wdata, s_ld, s_exc);
    n_checks++;
    if (s_ld !== 32'hA5ADBEEF)
      $display("FAIL store_readback: got %h want a5adbeef", s_ld);
    else n_pass++;
  endtask

  task automatic test_load_lat1();
    preload(0, 32'h2000, 32'h1234_80FF);
    do_access(0, 1'b1, 8'hE0, 32'h2001, 32'h0, s_stall, s_en, s_lv, s_wen, s_addr, s_wdata, s_ld, s_exc);
    n_checks++;
    if ({s_stall, s_en, s_lv, s_wen, s_addr, s_ld} !== {32'd2, 32'd1, 32'd1, 4'h0, 32'h2000, 32'hFFFFFF80})
      $display("FAIL lb_lat1: got stall=%0d en=%0d lv=%0d wen=%h addr=%h ld=%h, want 2 1 1 0 00002000 ffffff80",
               s_stall, s_en, s_lv, s_wen, s_addr, s_ld);
    else n_pass++;
    do_access(0, 1'b1, 8'hE4, 32'h2001, 32'h0, s_stall, s_en, s_lv, s_wen, s_addr, s_wdata, s_ld, s_exc);
    n_checks++;
    if ({s_stall, s_lv, s_ld} !== {32'd2, 32'd1, 32'h00000080})
      $display("FAIL lbu_lat1: got stall=%0d lv=%0d ld=%h, want 2 1 00000080", s_stall, s_lv, s_ld);
    else n_pass++;
    idle_inputs();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if ({lv[0], ld[0]} !== {1'b0, 32'h00000080})
        $display("FAIL load_hold: got lv=%b ld=%h want 0 00000080", lv[0], ld[0]);
      else n_pass++;
    end
  endtask

  task automatic test_load_lat3();
    preload(1, 32'h2000, 32'h8001_0000);
    do_access(1, 1'b1, 8'hE1, 32'h2002, 32'h0, s_stall, s_en, s_lv, s_wen, s_addr, s_wdata, s_ld, s_exc);
    n_checks++;
    if ({s_stall, s_en, s_lv, s_ld} !== {32'd4, 32'd1, 32'd1, 32'hFFFF8001})
      $display("FAIL lh_lat3: got stall=%0d en=%0d lv=%0d ld=%h, want 4 1 1 ffff8001", s_stall, s_en, s_lv, s_ld);
    else n_pass++;
  endtask

  task automatic test_flush();
    int seen_lv;
    int seen_en;
    @(posedge clk); #1;
    req_valid[1] = 1'b1; aluop[1] = 8'hE3; maddr[1] = 32'h2004;
    @(negedge clk);
    n_checks++;
    if ({en[1], stall[1]} !== 2'b11) $display("FAIL flush_issue: got en=%b stall=%b want 1 1", en[1], stall[1]);
    else n_pass++;
    @(posedge clk); #1;
    flush[1] = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({stall[1], lv[1], en[1]} !== 3'b000)
      $display("FAIL flush_wait: got stall=%b lv=%b en=%b want 0 0 0", stall[1], lv[1], en[1]);
    else n_pass++;
    @(posedge clk); #1;
    idle_inputs();
    seen_lv = 0; seen_en = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      seen_lv += int'(lv[1]); seen_en += int'(en[1]) + int'(stall[1]);
    end
    n_checks++;
    if (seen_lv != 0 || seen_en != 0)
      $display("FAIL flush_after: got lv_cycles=%0d en_or_stall_cycles=%0d want 0 0", seen_lv, seen_en);
    else n_pass++;
    // Agent must be back in IDLE and serve a normal load.
    do_access(1, 1'b1, 8'hE5, 32'h2002, 32'h0, s_stall, s_en, s_lv, s_wen, s_addr, s_wdata, s_ld, s_exc);
    n_checks++;
    if ({s_stall, s_en, s_lv, s_ld} !== {32'd4, 32'd1, 32'd1, 32'h00008001})
      $display("FAIL flush_recover: got stall=%0d en=%0d lv=%0d ld=%h want 4 1 1 00008001", s_stall, s_en, s_lv, s_ld);
    else n_pass++;
    // flush in IDLE masks a store.
    @(posedge clk); #1;
    req_valid[0] = 1'b1; aluop[0] = 8'hEB; maddr[0] = 32'h1000; reg2[0] = 32'h1; flush[0] = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({en[0], wen[0], stall[0]} !== 6'b0) $display("FAIL flush_idle: got en=%b wen=%h stall=%b want 0 0 0", en[0], wen[0], stall[0]);
    else n_pass++;
    // flush in DONE suppresses load_valid.
    @(posedge clk); #1;
    flush[0] = 1'b0; aluop[0] = 8'hE3; maddr[0] = 32'h2000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush[0] = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({lv[0], stall[0], en[0]} !== 3'b000) $display("FAIL flush_done: got lv=%b stall=%b en=%b want 0 0 0", lv[0], stall[0], en[0]);
    else n_pass++;
    @(posedge clk); #1;
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    int seen_lv;
    @(posedge clk); #1;
    req_valid[1] = 1'b1; aluop[1] = 8'hE3; maddr[1] = 32'h2000;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({stall[1], lv[1], en[1]} !== 3'b000) $display("FAIL reset_mid_out: got stall=%b lv=%b en=%b want 0 0 0", stall[1], lv[1], en[1]);
    else n_pass++;
    @(posedge clk); #1;
    rst = 1'b0;
    idle_inputs();
    seen_lv = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      seen_lv += int'(lv[1]) + int'(stall[1]);
    end
    n_checks++;
    if (seen_lv != 0 || ld[1] !== 32'h0)
      $display("FAIL reset_mid_late: got lv_or_stall_cycles=%0d ld=%h want 0 00000000", seen_lv, ld[1]);
    else n_pass++;
  endtask

  task automatic test_nonmem();
    do_access(0, 1'b0, 8'hE3, 32'h2000, 32'h0, s_stall, s_en, s_lv, s_wen, s_addr, s_wdata, s_ld, s_exc);
    n_checks++;
    if ({s_en, s_stall, s_lv} !== 96'd0) $display("FAIL no_valid: got en=%0d stall=%0d lv=%0d want 0 0 0", s_en, s_stall, s_lv);
    else n_pass++;
    do_access(0, 1'b1, 8'h21, 32'h2000, 32'h5, s_stall, s_en, s_lv, s_wen, s_addr, s_wdata, s_ld, s_exc);
    n_checks++;
    if ({s_en, s_stall, s_lv} !== 96'd0) $display("FAIL non_mem_op: got en=%0d stall=%0d lv=%0d want 0 0 0", s_en, s_stall, s_lv);
    else n_pass++;
  endtask

  task automatic test_align();
    preload(0, 32'h3000, 32'hCAFE_F00D);
    do_access(0, 1'b1, 8'hE3, 32'h3002, 32'h0, s_stall, s_en, s_lv, s_wen, s_addr, s_wdata, s_ld, s_exc);
    n_checks++;
`ifdef MEM_ALIGN_CHECK_EN
    if ({s_exc, s_en, s_stall} !== {2'b10, 32'd0, 32'd0})
      $display("FAIL align_lw: got exc=%b en=%0d stall=%0d want 10 0 0", s_exc, s_en, s_stall);
    else n_pass++;
`else
    if ({s_exc, s_en, s_addr, s_ld} !== {2'b00, 32'd1, 32'h3000, 32'hCAFEF00D})
      $display("FAIL align_lw: got exc=%b en=%0d addr=%h ld=%h want 00 1 00003000 cafef00d", s_exc, s_en, s_addr, s_ld);
    else n_pass++;
`endif
  endtask

  function automatic logic [7:0] pick_op(input int n);
    case (n)
      0: return 8'hE0; 1: return 8'hE4; 2: return 8'hE1; 3: return 8'hE5; 4: return 8'hE3;
      5: return 8'hE8; 6: return 8'hE9; 7: return 8'hEB; default: return 8'h00;
    endcase
  endfunction

  task automatic test_back_to_back();
    logic [7:0]  op;
    logic [31:0] a, d, exp_ld, exp_wd;
    logic [3:0]  exp_wen;
    logic        v, ld_op, st_op;
    for (int k = 0; k < 2; k++) begin
      for (int w = 0; w < 16; w++) preload(k, 32'h2000 + 32'(4 * w), $urandom);
      for (int i = 0; i < 40; i++) begin
        op = pick_op(int'($urandom_range(0, 8)));
        a  = 32'h2000 + 32'($urandom_range(0, 63));
        d  = $urandom;
        v  = ($urandom_range(0, 7) != 0);
`ifdef MEM_ALIGN_CHECK_EN
        if (op == 8'hE1 || op == 8'hE5 || op == 8'hE9) a[0] = 1'b0;
        if (op == 8'hE3 || op == 8'hEB) a[1:0] = 2'b00;
`endif
        ld_op  = v && is_ld(op);
        st_op  = v && is_st(op);
        exp_ld = ref_load(k, op, a);
        exp_wen = (op == 8'hE8) ? 4'(4'b0001 << a[1:0]) : (op == 8'hE9) ? (a[1] ? 4'b1100 : 4'b0011) : 4'hF;
        exp_wd  = (op == 8'hE8) ? {4{d[7:0]}} : (op == 8'hE9) ? {2{d[15:0]}} : d;
        do_access(k, v, op, a, d, s_stall, s_en, s_lv, s_wen, s_addr, s_wdata, s_ld, s_exc);
        n_checks++;
        if (s_stall != (ld_op ? lat_of(k) + 1 : 0) || s_en != int'(ld_op || st_op) || s_lv != int'(ld_op))
          $display("FAIL rand_ctrl[%0d.%0d] op=%h: got stall=%0d en=%0d lv=%0d want %0d %0d %0d", k, i, op,
                   s_stall, s_en, s_lv, ld_op ? lat_of(k) + 1 : 0, int'(ld_op || st_op), int'(ld_op));
        else n_pass++;
        if (st_op) begin
          ref_store(k, op, a, d);
          n_checks++;
          if ({s_wen, s_wdata, s_addr} !== {exp_wen, exp_wd, a[31:2], 2'b00})
            $display("FAIL rand_store[%0d.%0d] op=%h: got wen=%b wdata=%h addr=%h want %b %h %h", k, i, op,
                     s_wen, s_wdata, s_addr, exp_wen, exp_wd, {a[31:2], 2'b00});
          else n_pass++;
        end
        if (ld_op) begin
          n_checks++;
          if (s_ld !== exp_ld)
            $display("FAIL rand_load[%0d.%0d] op=%h addr=%h: got %h want %h", k, i, op, a, s_ld, exp_ld);
          else n_pass++;
        end
      end
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    test_reset();
    test_store();
    test_load_lat1();
    test_load_lat3();
    test_flush();
    test_reset_mid();
    test_nonmem();
    test_align();
    test_back_to_back();
    @(posedge clk); #1;
    idle_inputs();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
